// File: rtl/brush_painter_if.sv
// Brush painter bus interface.
//   master: decode side, drives brush/config strobes and watches frame-buffer writes.
//   slave : the painter, consumes brush/config and drives the frame-buffer write port.
// Signals:
//   brushUpdate, x, y            brush-event level strobe and coordinates
//   newColorUpdate, updateConfig colour value and config level strobe
//   memWe, memAddr, memData      frame-buffer write port
//   busy, overflow               painter activity and sticky drop flag
interface brush_painter_if #(
  parameter int unsigned ADDR_W = 15
);
  logic              brushUpdate;
  logic [7:0]        x;
  logic [7:0]        y;
  logic [2:0]        newColorUpdate;
  logic              updateConfig;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [2:0]        memData;
  logic              busy;
  logic              overflow;

  modport master (
    output brushUpdate, x, y, newColorUpdate, updateConfig,
    input  memWe, memAddr, memData, busy, overflow
  );

  modport slave (
    input  brushUpdate, x, y, newColorUpdate, updateConfig,
    output memWe, memAddr, memData, busy, overflow
  );
endinterface

// File: rtl/brush_painter.sv
// Brush painter: queues brush events from the decode stage and rasterises each into a
// BRUSH x BRUSH square of frame-buffer writes, one pixel per clock.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    brush_painter_if slave: brush/config strobes in, frame-buffer writes,
//          busy and sticky overflow out
module brush_painter #(
  parameter int unsigned WIDTH      = 160,
  parameter int unsigned HEIGHT     = 120,
  parameter int unsigned BRUSH      = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 15
) (
  input  logic           clk,
  input  logic           reset,
  brush_painter_if.slave bus
);

  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam logic [2:0]  BrushMax = 3'(BRUSH - 1);
  localparam logic [8:0]  WidthL   = 9'(WIDTH);
  localparam logic [8:0]  HeightL  = 9'(HEIGHT);

  typedef enum logic [1:0] {StIdle, StLoad, StPaint} state_e;

  state_e state_q, state_d;

  logic brush_q, cfg_q;
  logic brush_ev, cfg_ev;
  logic [2:0] cur_color_q;
  logic [2:0] color_sel;

  // FIFO entry layout: {x, y, colour}
  logic [18:0]     fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic            fifo_empty, fifo_full;
  logic            push, pop;
  logic [18:0]     head;

  logic [7:0] x0_q, y0_q;
  logic [2:0] col_q;
  logic [2:0] dx_q, dx_d, dy_q, dy_d;

  logic [8:0]        px, py;
  logic              mem_we;
  logic [ADDR_W-1:0] pix_addr;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        data_q;
  logic              overflow_q;

  assign brush_ev = bus.brushUpdate & ~brush_q;
  assign cfg_ev   = bus.updateConfig & ~cfg_q;
  // A config arriving in the same cycle as a brush event applies to that event.
  assign color_sel = cfg_ev ? bus.newColorUpdate : cur_color_q;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (PtrW + 1)'(FIFO_DEPTH));
  assign pop        = (state_q == StLoad);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push       = brush_ev & (~fifo_full | pop);
  assign head       = fifo_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brush_q     <= 1'b0;
      cfg_q       <= 1'b0;
      cur_color_q <= 3'b111;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      brush_q <= bus.brushUpdate;
      cfg_q   <= bus.updateConfig;
      count_q <= count_d;
      if (cfg_ev) begin
        cur_color_q <= bus.newColorUpdate;
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= {bus.x, bus.y, color_sel};
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (brush_ev && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        state_d = StPaint;
        dx_d    = 3'd0;
        dy_d    = 3'd0;
      end
      StPaint: begin
        if (dx_q == BrushMax) begin
          dx_d = 3'd0;
          if (dy_q == BrushMax) begin
            state_d = StIdle;
          end else begin
            dy_d = dy_q + 3'd1;
          end
        end else begin
          dx_d = dx_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      dx_q    <= 3'd0;
      dy_q    <= 3'd0;
      x0_q    <= 8'd0;
      y0_q    <= 8'd0;
      col_q   <= 3'd0;
      addr_q  <= '0;
      data_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      if (state_q == StLoad) begin
        x0_q  <= head[18:11];
        y0_q  <= head[10:3];
        col_q <= head[2:0];
      end
      if (mem_we) begin
        addr_q <= pix_addr;
        data_q <= col_q;
      end
    end
  end

  // 9-bit sums so squares near the right/bottom edge clip rather than wrap.
  assign px       = {1'b0, x0_q} + {6'd0, dx_q};
  assign py       = {1'b0, y0_q} + {6'd0, dy_q};
  assign mem_we   = (state_q == StPaint) && (px < WidthL) && (py < HeightL);
  assign pix_addr = ADDR_W'(py) * ADDR_W'(WIDTH) + ADDR_W'(px);

  // Address/data hold their last written value on clipped or idle cycles.
  assign bus.memWe    = mem_we;
  assign bus.memAddr  = mem_we ? pix_addr : addr_q;
  assign bus.memData  = mem_we ? col_q : data_q;
  assign bus.busy     = (state_q != StIdle) | ~fifo_empty;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_brush_painter.sv
// Testbench for brush_painter: directed scenarios plus randomized stimulus, checked every
// cycle against a timeline model of queued squares and their scheduled pixel writes.
module tb_brush_painter;

  localparam int W  = 160;
  localparam int H  = 120;
  localparam int B  = 3;
  localparam int D  = 4;
  localparam int BB = B * B;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  brush_painter_if #(.ADDR_W(15)) bus ();

  brush_painter #(
    .WIDTH     (W),
    .HEIGHT    (H),
    .BRUSH     (B),
    .FIFO_DEPTH(D),
    .ADDR_W    (15)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  int wr_seen;

  // Model: each accepted event gets a LOAD cycle; its pixels land in the following
  // BRUSH*BRUSH cycles and the next LOAD can come no sooner than two cycles later.
  int         ev_push[$];
  int         ev_load[$];
  int         next_load;
  int         ovf_at;
  logic [2:0] cur_col;
  logic       prev_bu, prev_uc;
  int         exp_addr[int];
  int         exp_data[int];
  int         last_addr, last_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    ev_push.delete();
    ev_load.delete();
    exp_addr.delete();
    exp_data.delete();
    next_load = 0;
    ovf_at    = -1;
    cur_col   = 3'd7;
    prev_bu   = 1'b0;
    prev_uc   = 1'b0;
    last_addr = 0;
    last_data = 0;
  endtask

  task automatic model_step(input logic bu, input logic [7:0] xx, input logic [7:0] yy,
                            input logic uc, input logic [2:0] nc);
    logic       bev, cev;
    logic [2:0] col;
    int         occ, ld, px, py;
    bev     = bu & ~prev_bu;
    cev     = uc & ~prev_uc;
    prev_bu = bu;
    prev_uc = uc;
    col     = cev ? nc : cur_col;
    if (cev) cur_col = nc;
    if (bev) begin
      occ = 0;
      foreach (ev_load[i]) if (ev_load[i] > cyc) occ++;
      if (occ < D) begin
        ld = (cyc + 2 > next_load) ? cyc + 2 : next_load;
        ev_push.push_back(cyc);
        ev_load.push_back(ld);
        next_load = ld + BB + 2;
        for (int i = 0; i < BB; i++) begin
          px = int'(xx) + i % B;
          py = int'(yy) + i / B;
          if (px < W && py < H) begin
            exp_addr[ld + 1 + i] = py * W + px;
            exp_data[ld + 1 + i] = int'(col);
          end
        end
      end else if (ovf_at < 0) begin
        ovf_at = cyc + 1;
      end
    end
  endtask

  task automatic check_outputs();
    logic we_e, busy_e, ovf_e;
    we_e = exp_addr.exists(cyc);
    if (we_e) begin
      last_addr = exp_addr[cyc];
      last_data = exp_data[cyc];
    end
    busy_e = 1'b0;
    foreach (ev_load[i]) if (ev_push[i] < cyc && ev_load[i] + BB >= cyc) busy_e = 1'b1;
    ovf_e = (ovf_at >= 0) && (cyc >= ovf_at);
    check("memWe", 32'(bus.memWe), 32'(we_e));
    check("memAddr", 32'(bus.memAddr), last_addr);
    check("memData", 32'(bus.memData), last_data);
    check("busy", 32'(bus.busy), 32'(busy_e));
    check("overflow", 32'(bus.overflow), 32'(ovf_e));
    if (bus.memWe === 1'b1) wr_seen++;
  endtask

  task automatic tick(input logic bu, input logic [7:0] xx, input logic [7:0] yy,
                      input logic uc, input logic [2:0] nc);
    bus.brushUpdate    = bu;
    bus.x              = xx;
    bus.y              = yy;
    bus.updateConfig   = uc;
    bus.newColorUpdate = nc;
    model_step(bu, xx, yy, uc, nc);
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'd0, 8'd0, 1'b0, 3'd0);
  endtask

  task automatic do_reset();
    bus.brushUpdate    = 1'b0;
    bus.x              = 8'd0;
    bus.y              = 8'd0;
    bus.updateConfig   = 1'b0;
    bus.newColorUpdate = 3'd0;
    reset = 1'b1;
    #1;
    check("rst_memWe", 32'(bus.memWe), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cyc = 0;
    check_outputs();
  endtask

  initial begin
    reset = 1'b0;
    model_reset();
    cyc = 0;
    #2;
    do_reset();

    // Single square at default colour.
    wr_seen = 0;
    tick(1'b1, 8'd10, 8'd20, 1'b0, 3'd0);
    idle(14);
    check("sq1_writes", wr_seen, 32'd9);

    // Config then brush at origin.
    tick(1'b0, 8'd0, 8'd0, 1'b1, 3'd2);
    tick(1'b0, 8'd0, 8'd0, 1'b0, 3'd2);
    tick(1'b1, 8'd0, 8'd0, 1'b0, 3'd0);
    idle(14);

    // Same-cycle config and brush: the new colour wins over the previous one.
    tick(1'b0, 8'd0, 8'd0, 1'b1, 3'd6);
    tick(1'b0, 8'd0, 8'd0, 1'b0, 3'd6);
    tick(1'b1, 8'd0, 8'd0, 1'b1, 3'd2);
    idle(14);

    // Bottom-right corner: only one pixel survives clipping.
    wr_seen = 0;
    tick(1'b1, 8'd159, 8'd119, 1'b0, 3'd0);
    idle(14);
    check("clip_writes", wr_seen, 32'd1);

    // Six rising edges while painting: the sixth finds the FIFO full.
    wr_seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, 8'(k * 20), 8'(k * 10), 1'b0, 3'd0);
      tick(1'b0, 8'd0, 8'd0, 1'b0, 3'd0);
    end
    idle(70);
    check("ovf_writes", wr_seen, 32'd45);

    // Colour latched per event.
    do_reset();
    tick(1'b1, 8'd30, 8'd30, 1'b0, 3'd0);
    tick(1'b0, 8'd0, 8'd0, 1'b0, 3'd0);
    tick(1'b0, 8'd0, 8'd0, 1'b1, 3'd5);
    tick(1'b0, 8'd0, 8'd0, 1'b0, 3'd5);
    tick(1'b1, 8'd40, 8'd40, 1'b0, 3'd0);
    idle(30);

    // Randomized traffic, including off-screen coordinates and FIFO pressure.
    for (int i = 0; i < 1500; i++) begin
      tick(($urandom_range(0, 2) == 0), 8'($urandom_range(0, 165)), 8'($urandom_range(0, 125)),
           ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
    end
    idle(80);

    // Held level gives exactly one square.
    wr_seen = 0;
    for (int i = 0; i < 20; i++) tick(1'b1, 8'd60, 8'd60, 1'b0, 3'd0);
    idle(10);
    check("held_writes", wr_seen, 32'd9);

    // Force overflow, then reset mid-square.
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, 8'd70, 8'd70, 1'b0, 3'd0);
      tick(1'b0, 8'd0, 8'd0, 1'b0, 3'd0);
    end
    idle(3);
    do_reset();

    // After reset: queue is empty and colour is back to 7.
    wr_seen = 0;
    tick(1'b1, 8'd5, 8'd5, 1'b0, 3'd0);
    idle(20);
    check("post_rst_writes", wr_seen, 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/brush_painter.md
Name: brush_painter

Overview:
- Downstream consumer of the SPI decode stage.
- Takes brush events (x, y) and colour-config updates, and queues brush events in a small FIFO.
- Rasterises each event into a BRUSH x BRUSH square of pixel writes, one pixel per clock, on the frame-buffer write port.
- Sits between the SPI receive/decode path and the frame-buffer RAM.

Parameters:
- WIDTH, 160, screen width in pixels.
- HEIGHT, 120, screen height in pixels.
- BRUSH, 3, brush square side length in pixels (1..8).
- FIFO_DEPTH, 4, brush-event queue depth (power of 2).
- ADDR_W, 15, frame-buffer address width (must hold WIDTH*HEIGHT-1).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- brushUpdate  input  1  brush-event strobe from decode (level; rising edge = one event).
- x  input  8  brush column, valid when brushUpdate rises.
- y  input  8  brush row, valid when brushUpdate rises.
- newColorUpdate  input  3  colour value, valid when updateConfig rises.
- updateConfig  input  1  config strobe (level; rising edge = colour load).
- memWe  output  1  frame-buffer write enable.
- memAddr  output  ADDR_W  pixel address, y*WIDTH + x.
- memData  output  3  pixel colour.
- busy  output  1  high while FIFO non-empty or painter not IDLE.
- overflow  output  1  sticky: a brush event was dropped because the FIFO was full.

Behaviour:
- One clock domain: clk. reset is asynchronous, active-high. All flops clear immediately on reset assertion.
- Reset values: memWe=0, memAddr=0, memData=0, busy=0, overflow=0, state=IDLE, FIFO empty, curColor=3'b111, edge-detect registers=0.
- Reset mid-paint aborts the square; remaining pixels and queued events are discarded.
- Edge detect: registered copies of brushUpdate and updateConfig.
  - brushEv = brushUpdate & ~brushUpdate_q.
  - cfgEv = updateConfig & ~updateConfig_q.
  - A level held high produces exactly one event.
- Colour: on cfgEv, curColor <= newColorUpdate.
- Enqueue: on brushEv, push {x, y, colorSel}.
  - colorSel = newColorUpdate if cfgEv is in the same cycle, else curColor. The same-cycle config wins.
  - Colour is latched per event; later config changes do not affect queued events.
- FIFO full and brushEv: event dropped, overflow <= 1. overflow clears only on reset.
- Push and pop in the same cycle are legal:
  - When full, the pop frees the slot and the push succeeds.
  - When empty, the push lands and the pop is not taken that cycle.
- FSM:
  - IDLE: if FIFO non-empty -> LOAD.
  - LOAD: pop the head; latch x0, y0, col; dx=0, dy=0 -> PAINT.
  - PAINT: one pixel per cycle at (x0+dx, y0+dy).
    - dx increments each cycle. At dx=BRUSH-1, dx wraps to 0 and dy increments.
    - After the pixel (BRUSH-1, BRUSH-1) -> IDLE.
- Pixel output, during PAINT:
  - memWe=1 iff x0+dx < WIDTH and y0+dy < HEIGHT.
  - memAddr = (y0+dy)*WIDTH + (x0+dx); memData=col.
  - Coordinate sums are computed at 9 bits to avoid wrap. Clipped pixels still take their cycle with memWe=0.
  - memAddr and memData hold their last value when memWe=0.
- Outputs are combinational from the PAINT registers; no extra pipeline stage.
- Latency, idle with empty FIFO:
  - brushUpdate rise sampled in cycle 0 -> pushed end of cycle 0 -> LOAD in cycle 2 -> first pixel in cycle 3.
  - Last pixel in cycle 3+BRUSH*BRUSH-1.
  - Each square takes exactly BRUSH*BRUSH PAINT cycles.
  - Back-to-back queued squares incur 2 idle cycles (IDLE, LOAD) between PAINT runs.
- busy = (state != IDLE) | ~fifoEmpty. It goes high the cycle after the push and low the cycle after the last PAINT with the FIFO empty.

Test Plan:
- Reset, then one brush event x=10, y=20, default colour:
  - Exactly 9 writes in cycles 3..11.
  - Addresses 3210, 3211, 3212, 3370, 3371, 3372, 3530, 3531, 3532; memData=7.
  - busy falls after the last write.
- updateConfig rise with newColorUpdate=3'd2, then brush x=0, y=0:
  - Writes at 0, 1, 2, 160, 161, 162, 320, 321, 322 with memData=2.
  - Repeat with config and brush in the same cycle: memData=2 again.
- Clipping, brush x=159, y=119:
  - Exactly one memWe pulse, addr=19199.
  - busy high for 9 PAINT cycles plus the 2 lead cycles.
- Overflow: 6 brush events on consecutive rising edges while painting:
  - 4 queued; the event arriving when full is dropped and overflow=1.
  - Exactly 5 squares painted in arrival order, with 2-cycle gaps.
- Colour latching: queue brush A, set colour 3'd5, queue brush B, all before A finishes. A paints colour 7, B paints colour 5.
- Held level: brushUpdate held high for 20 cycles -> exactly one square. Assert reset mid-square -> memWe=0 immediately, FIFO empty, overflow=0, curColor=7.
